// File: rtl/usb_rx_decoder.sv
// usb_rx_decoder: USB full-speed receiver (sync, NRZI, destuff, PID/EOP checks, 2-byte CRC holdback).
// Define RX_CRC16_CHECK_EN to check the DATA CRC16 residual at EOP.
module usb_rx_decoder #(
  parameter int CLKS_PER_BIT = 8,
  parameter logic [6:0] DEV_ADDR = 7'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       dplus_in,
  input  logic       dminus_in,
  input  logic [6:0] buff_occ,
  output logic [2:0] rx_packet,
  output logic       rx_packet_valid,
  output logic       rx_transfer_active,
  output logic       rx_error,
  output logic       store_rx_packet_data,
  output logic [7:0] rx_packet_data,
  output logic       flush
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  typedef enum logic [2:0] {IDLE, SYNC, PID, BODY, EOP, WAIT_IDLE} state_t;
  state_t state, nstate;
  logic dp_m, dp_s, dm_m, dm_s;
  logic [1:0] line, line_q, se0_cnt;
  logic [CW-1:0] cnt, idle_cnt;
  logic smp, se0, j, k, prev, dbit, stuff, data_ev, stuff_err, byte_done;
  logic [2:0] ones, bcnt, ptype, btype;
  logic [7:0] sh, byte_v, nbytes, hold0, hold1;
  logic [6:0] addr;
  logic pushed, is_tok, is_data, err, fin, push, crc_ok, good;
  assign line = {dp_s, dm_s};
  assign se0 = line == 2'b00;
  assign j = line == 2'b10;
  assign k = line == 2'b01;
  assign smp = cnt == CW'(CLKS_PER_BIT / 2);
  assign dbit = dp_s == prev;
  assign stuff = ones == 3'd6;
  assign data_ev = smp && !se0 && !stuff;
  assign stuff_err = smp && !se0 && stuff && dbit;
  assign byte_done = data_ev && bcnt == 3'd7;
  assign byte_v = {dbit, sh[7:1]};
  assign btype = byte_v == 8'hE1 ? 3'd1 : byte_v == 8'h69 ? 3'd2 : byte_v == 8'hC3 ? 3'd3 :
                 byte_v == 8'h4B ? 3'd4 : byte_v == 8'hD2 ? 3'd5 : byte_v == 8'h5A ? 3'd6 :
                 byte_v == 8'h1E ? 3'd7 : 3'd0;
  assign is_tok = ptype == 3'd1 || ptype == 3'd2;
  assign is_data = ptype == 3'd3 || ptype == 3'd4;
  assign rx_transfer_active = state inside {SYNC, PID, BODY, EOP};
  assign good = fin && !err && !(is_tok && addr != DEV_ADDR);
`ifdef RX_CRC16_CHECK_EN
  logic [15:0] crc;
  assign crc_ok = !is_data || crc == 16'h800D;
`else
  assign crc_ok = 1'b1;
`endif
  always_comb begin
    nstate = state;
    err = 1'b0;
    fin = 1'b0;
    push = 1'b0;
    case (state)
      IDLE: nstate = k ? SYNC : IDLE;
      SYNC: begin
        err = (smp && se0) || stuff_err || (byte_done && byte_v != 8'h80);
        if (byte_done) nstate = PID;
      end
      PID: begin
        err = (smp && se0) || stuff_err || (byte_done && btype == 3'd0);
        if (byte_done) nstate = btype >= 3'd5 ? EOP : BODY;
      end
      BODY: begin
        push = byte_done && is_data && nbytes >= 8'd2;
        err = (smp && se0 && bcnt != 3'd0) || stuff_err || (push && buff_occ >= 7'd64);
        if (smp && se0) nstate = EOP;
      end
      EOP: if (smp) begin
        fin = j && se0_cnt == 2'd2;
        err = (!se0 && !fin) || (se0 && se0_cnt == 2'd2) ||
              (fin && ((is_tok && nbytes != 8'd2) || (is_data && nbytes < 8'd2) || !crc_ok));
        if (fin) nstate = IDLE;
      end
      WAIT_IDLE: nstate = j && idle_cnt == CW'(CLKS_PER_BIT - 1) ? IDLE : WAIT_IDLE;
      default: nstate = IDLE;
    endcase
    if (err) nstate = WAIT_IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nstate;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {dp_m, dp_s, dm_m, dm_s} <= 4'b1100;
      line_q <= 2'b10;
      cnt <= '0;
      idle_cnt <= '0;
      store_rx_packet_data <= 1'b0;
      rx_packet_data <= '0;
      rx_packet_valid <= 1'b0;
      rx_packet <= '0;
      flush <= 1'b0;
      rx_error <= 1'b0;
      prev <= 1'b1;
      ones <= '0;
      bcnt <= '0;
      sh <= '0;
      nbytes <= '0;
      pushed <= 1'b0;
      se0_cnt <= '0;
      ptype <= '0;
      addr <= '0;
      hold0 <= '0;
      hold1 <= '0;
`ifdef RX_CRC16_CHECK_EN
      crc <= 16'hFFFF;
`endif
    end else begin
      {dp_m, dp_s, dm_m, dm_s} <= {dplus_in, dp_m, dminus_in, dm_m};
      line_q <= line;
      cnt <= (line != line_q || cnt == CW'(CLKS_PER_BIT - 1)) ? '0 : cnt + 1'b1;
      idle_cnt <= state == WAIT_IDLE && j ? idle_cnt + 1'b1 : '0;
      store_rx_packet_data <= push && !err;
      if (push && !err) rx_packet_data <= hold0;
      rx_packet_valid <= good;
      rx_packet <= good ? ptype : 3'd0;
      flush <= err && is_data && pushed;
      rx_error <= state == IDLE && k ? 1'b0 : rx_error | err;
      if (state == IDLE) begin
        prev <= 1'b1;
        ones <= '0;
        bcnt <= '0;
        nbytes <= '0;
        pushed <= 1'b0;
        se0_cnt <= '0;
        ptype <= '0;
`ifdef RX_CRC16_CHECK_EN
        crc <= 16'hFFFF;
`endif
      end else if (smp) begin
        if (se0) se0_cnt <= se0_cnt + 1'b1;
        else begin
          prev <= dp_s;
          ones <= dbit && !stuff ? ones + 1'b1 : '0;
          if (!stuff) begin
            sh <= byte_v;
            bcnt <= bcnt + 1'b1;
          end
        end
        if (byte_done && state == PID) ptype <= btype;
        // Two-deep holdback so the trailing CRC bytes never reach the buffer
        if (byte_done && state == BODY) begin
          nbytes <= nbytes == 8'hFF ? nbytes : nbytes + 1'b1;
          if (nbytes == 8'd0) addr <= byte_v[6:0];
          hold0 <= hold1;
          hold1 <= byte_v;
        end
`ifdef RX_CRC16_CHECK_EN
        if (data_ev && state == BODY && is_data)
          crc <= {crc[14:0], 1'b0} ^ ((dbit ^ crc[15]) ? 16'h8005 : 16'h0000);
`endif
        if (push && !err) pushed <= 1'b1;
      end
    end
  end
endmodule
